// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter.
//   DIGIT_W     : width of one decimal digit field
//   MAX_DIGITS  : widest supported counter, in digits
//   digit_field : extracts digit idx from a MAX_DIGITS-wide packed bus
package bcd_updown_counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  function automatic logic [DIGIT_W-1:0] digit_field(
    input logic [DIGIT_W*MAX_DIGITS-1:0] bus,
    input int                            idx
  );
    return bus[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One decade digit of the cascaded counter.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Clear      : synchronous clear to 0 (highest priority)
//   Load       : synchronous load of LoadDigit, saturated to DIGIT_MAX
//   LoadDigit  : value to load
//   StepIn     : step this digit this cycle
//   Up         : 1 = increment, 0 = decrement
//   Digit      : registered digit value, 0..DIGIT_MAX
//   StepOut    : this digit rolls over on the current step (carry/borrow)
module bcd_digit
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGIT_MAX = 9
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Clear,
  input  logic               Load,
  input  logic [DIGIT_W-1:0] LoadDigit,
  input  logic               StepIn,
  input  logic               Up,
  output logic [DIGIT_W-1:0] Digit,
  output logic               StepOut
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(DIGIT_MAX);

  // Loaded values above the terminal digit are clamped so the digit never
  // leaves its legal range.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  logic at_max;
  logic at_zero;

  assign at_max  = (Digit == MAX_V);
  assign at_zero = (Digit == '0);
  assign StepOut = StepIn & (Up ? at_max : at_zero);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Digit <= '0;
    end else if (Clear) begin
      Digit <= '0;
    end else if (Load) begin
      Digit <= sat_digit(LoadDigit);
    end else if (StepIn) begin
      if (Up) Digit <= at_max  ? '0    : Digit + 4'd1;
      else    Digit <= at_zero ? MAX_V : Digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit up/down decade counter.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   ClkEnable  : count strobe, one step per cycle when high
//   Up         : 1 = increment, 0 = decrement
//   Clear      : synchronous clear to all-zero
//   Load       : synchronous load of LoadValue (digits saturated to DIGIT_MAX)
//   LoadValue  : packed digits, digit 0 in [3:0]
//   Count      : registered count, digit 0 in [3:0]
//   TermCount  : combinational, next enabled step wraps the whole counter
//   Wrap       : registered one-cycle pulse after a full wrap
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      ClkEnable,
  input  logic                      Up,
  input  logic                      Clear,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] LoadValue,
  output logic [DIGIT_W*DIGITS-1:0] Count,
  output logic                      TermCount,
  output logic                      Wrap
);

  // Ripple step chain: step[k] enables digit k, step[DIGITS] means the
  // whole counter rolls over on this step.
  logic [DIGITS:0]                  step;
  logic [DIGIT_W*MAX_DIGITS-1:0]    load_bus;

  always_comb begin
    load_bus = '0;
    load_bus[DIGIT_W*DIGITS-1:0] = LoadValue;
  end

  assign step[0] = ClkEnable;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit #(
      .DIGIT_MAX (DIGIT_MAX)
    ) u_digit (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Clear     (Clear),
      .Load      (Load),
      .LoadDigit (digit_field(load_bus, k)),
      .StepIn    (step[k]),
      .Up        (Up),
      .Digit     (Count[k*DIGIT_W +: DIGIT_W]),
      .StepOut   (step[k+1])
    );
  end

  // Clear/Load override any step, so they must also mask the cascade output.
  assign TermCount = step[DIGITS] & ~Clear & ~Load;

  // TermCount is already zero on Clear/Load, so it is exactly the wrap event.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Wrap <= 1'b0;
    else        Wrap <= TermCount;
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        ClkEnable, Up, Clear, Load;
  logic [15:0] LoadValue;
  logic [15:0] Count;
  logic        TermCount, Wrap;

  logic        ClkEnable1, Up1, Clear1, Load1;
  logic [3:0]  LoadValue1;
  logic [3:0]  Count1;
  logic        TermCount1, Wrap1;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  bcd_updown_counter #(.DIGITS(4), .DIGIT_MAX(9)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ClkEnable(ClkEnable), .Up(Up),
    .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Count(Count), .TermCount(TermCount), .Wrap(Wrap)
  );

  bcd_updown_counter #(.DIGITS(1), .DIGIT_MAX(9)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .ClkEnable(ClkEnable1), .Up(Up1),
    .Clear(Clear1), .Load(Load1), .LoadValue(LoadValue1),
    .Count(Count1), .TermCount(TermCount1), .Wrap(Wrap1)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load4(input logic [15:0] v);
    ClkEnable = 1'b0; Clear = 1'b0; Load = 1'b1; LoadValue = v;
    tick();
    Load = 1'b0;
  endtask

  task automatic test_reset();
    ClkEnable = 0; Up = 1; Clear = 0; Load = 0; LoadValue = '0;
    ClkEnable1 = 0; Up1 = 1; Clear1 = 0; Load1 = 0; LoadValue1 = '0;
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (Count !== 16'h0000 || Wrap !== 1'b0 || TermCount !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: Count=%h Wrap=%b TermCount=%b, required 0000/0/0", Count, Wrap, TermCount);
    end
    tick();
    Rst_n = 1'b1;
    load4(16'h0456);
    ClkEnable = 1; Up = 1;
    tick();
    checks++;
    if (Count !== 16'h0457) begin
      errors++;
      $display("FAIL reset_precount: Count=%h, required 0457", Count);
    end
    #3 Rst_n = 1'b0;
    #1;
    checks++;
    if (Count !== 16'h0000 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Count=%h Wrap=%b, required 0000/0", Count, Wrap);
    end
    ClkEnable = 0;
    #1 Rst_n = 1'b1;
    tick();
    checks++;
    if (Count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_hold: Count=%h, required 0000", Count);
    end
  endtask

  task automatic test_up_carry();
    load4(16'h0998);
    ClkEnable = 1; Up = 1;
    tick();
    checks++;
    if (Count !== 16'h0999 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_step1: Count=%h Wrap=%b, required 0999/0", Count, Wrap);
    end
    tick();
    checks++;
    if (Count !== 16'h1000 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_carry3: Count=%h Wrap=%b, required 1000/0", Count, Wrap);
    end
    ClkEnable = 0;
  endtask

  task automatic test_full_wrap_up();
    load4(16'h9999);
    ClkEnable = 1; Up = 1;
    #1;
    checks++;
    if (TermCount !== 1'b1) begin
      errors++;
      $display("FAIL term_up: TermCount=%b, required 1", TermCount);
    end
    tick();
    checks++;
    if (Count !== 16'h0000 || Wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: Count=%h Wrap=%b, required 0000/1", Count, Wrap);
    end
    checks++;
    if (TermCount !== 1'b0) begin
      errors++;
      $display("FAIL term_after_wrap: TermCount=%b, required 0", TermCount);
    end
    ClkEnable = 0;
    tick();
    checks++;
    if (Count !== 16'h0000 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_pulse_end: Count=%h Wrap=%b, required 0000/0", Count, Wrap);
    end
  endtask

  task automatic test_down();
    load4(16'h0000);
    ClkEnable = 1; Up = 0;
    #1;
    checks++;
    if (TermCount !== 1'b1) begin
      errors++;
      $display("FAIL term_down: TermCount=%b, required 1", TermCount);
    end
    tick();
    checks++;
    if (Count !== 16'h9999 || Wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: Count=%h Wrap=%b, required 9999/1", Count, Wrap);
    end
    ClkEnable = 0;
    tick();
    checks++;
    if (Wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down_pulse_end: Wrap=%b, required 0", Wrap);
    end
    load4(16'h1000);
    ClkEnable = 1; Up = 0;
    tick();
    checks++;
    if (Count !== 16'h0999 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_borrow3: Count=%h Wrap=%b, required 0999/0", Count, Wrap);
    end
    ClkEnable = 0;
  endtask

  task automatic test_direction_change();
    load4(16'h0500);
    ClkEnable = 1; Up = 1;
    tick();
    checks++;
    if (Count !== 16'h0501) begin
      errors++;
      $display("FAIL dir_up: Count=%h, required 0501", Count);
    end
    Up = 0;
    tick();
    checks++;
    if (Count !== 16'h0500) begin
      errors++;
      $display("FAIL dir_down1: Count=%h, required 0500", Count);
    end
    tick();
    checks++;
    if (Count !== 16'h0499) begin
      errors++;
      $display("FAIL dir_down2: Count=%h, required 0499", Count);
    end
    ClkEnable = 0;
  endtask

  task automatic test_load_clear();
    load4(16'h9999);
    ClkEnable = 1; Up = 1; Load = 1; LoadValue = 16'h3C5F;
    #1;
    checks++;
    if (TermCount !== 1'b0) begin
      errors++;
      $display("FAIL term_masked_load: TermCount=%b, required 0", TermCount);
    end
    tick();
    checks++;
    if (Count !== 16'h3959 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_saturate: Count=%h Wrap=%b, required 3959/0", Count, Wrap);
    end
    Clear = 1; Load = 1; LoadValue = 16'h1234;
    tick();
    checks++;
    if (Count !== 16'h0000 || Wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_over_load: Count=%h Wrap=%b, required 0000/0", Count, Wrap);
    end
    Load = 0; Up = 0;
    #1;
    checks++;
    if (TermCount !== 1'b0) begin
      errors++;
      $display("FAIL term_masked_clear: TermCount=%b, required 0", TermCount);
    end
    Clear = 0; ClkEnable = 0;
  endtask

  task automatic test_hold();
    load4(16'h0457);
    ClkEnable = 0;
    for (int i = 0; i < 10; i++) begin
      Up = i[0];
      #1;
      checks++;
      if (TermCount !== 1'b0) begin
        errors++;
        $display("FAIL hold_term[%0d]: TermCount=%b, required 0", i, TermCount);
      end
      tick();
      checks++;
      if (Count !== 16'h0457 || Wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_count[%0d]: Count=%h Wrap=%b, required 0457/0", i, Count, Wrap);
      end
    end
  endtask

  task automatic test_single_digit();
    Load1 = 1; LoadValue1 = 4'hF;
    tick();
    Load1 = 0;
    checks++;
    if (Count1 !== 4'h9) begin
      errors++;
      $display("FAIL d1_load_sat: Count=%h, required 9", Count1);
    end
    ClkEnable1 = 1; Up1 = 1;
    #1;
    checks++;
    if (TermCount1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_term_up: TermCount=%b, required 1", TermCount1);
    end
    tick();
    checks++;
    if (Count1 !== 4'h0 || Wrap1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_wrap_up: Count=%h Wrap=%b, required 0/1", Count1, Wrap1);
    end
    Up1 = 0;
    tick();
    checks++;
    if (Count1 !== 4'h9 || Wrap1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_wrap_down: Count=%h Wrap=%b, required 9/1", Count1, Wrap1);
    end
    tick();
    checks++;
    if (Count1 !== 4'h8 || Wrap1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_down: Count=%h Wrap=%b, required 8/0", Count1, Wrap1);
    end
    ClkEnable1 = 0;
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_full_wrap_up();
    test_down();
    test_direction_change();
    test_load_clear();
    test_hold();
    test_single_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
